// File: rtl/fpu_add_sub_16.sv
// rtl/fpu_add_sub_16.sv - binary16 adder/subtractor with registered result and ZCNV flags
module fpu_add_sub_16 (
    input  logic        clock,
    input  logic        reset_L,
    input  logic        sub,
    input  logic [15:0] fpuIn1,
    input  logic [15:0] fpuIn2,
    output logic [15:0] fpuOut,
    output logic [3:0]  condCodes
);

    localparam logic [15:0] QNAN = 16'h7E00;

    // Operand fields; B's sign already folded with the operation select
    logic        a_sign, b_sign;
    logic [4:0]  a_exp, b_exp;
    logic [9:0]  a_frac, b_frac;
    logic        a_nan, b_nan, a_inf, b_inf;

    // Ordered operands (big has the larger magnitude)
    logic        swap;
    logic        big_sign, small_sign;
    logic [4:0]  big_exp, small_exp;
    logic [9:0]  big_frac, small_frac;
    logic [4:0]  big_exp_eff, small_exp_eff;
    logic [10:0] big_sig, small_sig;
    logic [4:0]  exp_diff;

    // Alignment and magnitude add/subtract: {hidden, frac[9:0], guard, round, sticky}
    logic [13:0] big_al, small_ext, small_shift, lost_mask, small_al;
    logic        eff_sub;
    logic [14:0] raw_sum;
    logic        carry;

    // Normalisation
    logic [3:0]  lz;
    logic [4:0]  max_shift, shamt;
    logic [13:0] norm;
    logic [5:0]  norm_exp;

    // Rounding
    logic [10:0] mant;
    logic        guard, rest, round_up;
    logic [11:0] mant_r;
    logic [10:0] final_mant;
    logic [5:0]  final_exp;
    logic [4:0]  enc_exp;
    logic        overflow;

    // Registered result and flags
    logic [15:0] fpu_out_d, fpu_out_q;
    logic [3:0]  cond_codes_d, cond_codes_q;
    logic        flag_z, flag_c, flag_n, flag_v;

    // Field decode and special-value classification
    always_comb begin
        a_sign = fpuIn1[15];
        a_exp  = fpuIn1[14:10];
        a_frac = fpuIn1[9:0];
        b_sign = fpuIn2[15] ^ sub;
        b_exp  = fpuIn2[14:10];
        b_frac = fpuIn2[9:0];
        a_nan  = (a_exp == 5'h1F) && (a_frac != 10'd0);
        b_nan  = (b_exp == 5'h1F) && (b_frac != 10'd0);
        a_inf  = (a_exp == 5'h1F) && (a_frac == 10'd0);
        b_inf  = (b_exp == 5'h1F) && (b_frac == 10'd0);
    end

    // Order operands by magnitude; subnormals use exponent 1 with hidden bit 0
    always_comb begin
        swap       = {b_exp, b_frac} > {a_exp, a_frac};
        big_sign   = swap ? b_sign : a_sign;
        small_sign = swap ? a_sign : b_sign;
        big_exp    = swap ? b_exp  : a_exp;
        small_exp  = swap ? a_exp  : b_exp;
        big_frac   = swap ? b_frac : a_frac;
        small_frac = swap ? a_frac : b_frac;

        big_exp_eff   = (big_exp   == 5'd0) ? 5'd1 : big_exp;
        small_exp_eff = (small_exp == 5'd0) ? 5'd1 : small_exp;
        big_sig       = {(big_exp   != 5'd0), big_frac};
        small_sig     = {(small_exp != 5'd0), small_frac};
        exp_diff      = big_exp_eff - small_exp_eff;
    end

    // Align the smaller significand, folding shifted-out bits into sticky
    always_comb begin
        big_al      = {big_sig, 3'b000};
        small_ext   = {small_sig, 3'b000};
        small_shift = 14'd0;
        lost_mask   = 14'd0;
        if (exp_diff > 5'd13) begin
            // Everything lands below the sticky position
            small_al = {13'd0, |small_sig};
        end else begin
            small_shift = small_ext >> exp_diff;
            lost_mask   = (14'd1 << exp_diff) - 14'd1;
            small_al    = small_shift | {13'd0, |(small_ext & lost_mask)};
        end
    end

    // Magnitude add or subtract; big >= small so subtraction never wraps
    always_comb begin
        eff_sub = big_sign ^ small_sign;
        if (eff_sub) begin
            raw_sum = {1'b0, big_al} - {1'b0, small_al};
        end else begin
            raw_sum = {1'b0, big_al} + {1'b0, small_al};
        end
        carry = raw_sum[14] & ~eff_sub;
    end

    // Normalise: carry shifts right once, otherwise shift left but never below exponent 1
    always_comb begin
        lz = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (raw_sum[i]) begin
                lz = 4'(13 - i);
            end
        end
        max_shift = big_exp_eff - 5'd1;
        shamt     = ({1'b0, lz} > max_shift) ? max_shift : {1'b0, lz};
        if (raw_sum[14]) begin
            norm     = {raw_sum[14:2], raw_sum[1] | raw_sum[0]};
            norm_exp = {1'b0, big_exp_eff} + 6'd1;
        end else begin
            norm     = raw_sum[13:0] << shamt;
            norm_exp = {1'b0, big_exp_eff} - {1'b0, shamt};
        end
    end

    // Round to nearest, ties to even; a rounding carry renormalises
    always_comb begin
        mant     = norm[13:3];
        guard    = norm[2];
        rest     = norm[1] | norm[0];
        round_up = guard & (rest | mant[0]);
        mant_r   = {1'b0, mant} + {11'd0, round_up};
        if (mant_r[11]) begin
            final_mant = mant_r[11:1];
            final_exp  = norm_exp + 6'd1;
        end else begin
            final_mant = mant_r[10:0];
            final_exp  = norm_exp;
        end
        // A result still lacking its hidden bit is subnormal and encodes exponent 0
        enc_exp  = final_mant[10] ? final_exp[4:0] : 5'd0;
        overflow = final_exp >= 6'd31;
    end

    // Result selection: specials first, then zero, overflow and ordinary results
    always_comb begin
        fpu_out_d = {big_sign, enc_exp, final_mant[9:0]};
        flag_z    = 1'b0;
        flag_c    = carry;
        flag_n    = big_sign;
        flag_v    = 1'b0;
        if (a_nan || b_nan) begin
            fpu_out_d = QNAN;
            flag_c    = 1'b0;
            flag_n    = 1'b0;
        end else if (a_inf && b_inf) begin
            flag_c = 1'b0;
            if (a_sign == b_sign) begin
                fpu_out_d = {a_sign, 15'h7C00};
                flag_n    = a_sign;
            end else begin
                fpu_out_d = QNAN;
                flag_n    = 1'b0;
            end
        end else if (a_inf) begin
            fpu_out_d = {a_sign, 15'h7C00};
            flag_c    = 1'b0;
            flag_n    = a_sign;
        end else if (b_inf) begin
            fpu_out_d = {b_sign, 15'h7C00};
            flag_c    = 1'b0;
            flag_n    = b_sign;
        end else if (raw_sum == 15'd0) begin
            // Exact zero is +0 unless both effective operands are negative
            fpu_out_d = {a_sign & b_sign, 15'd0};
            flag_z    = 1'b1;
            flag_c    = 1'b0;
            flag_n    = a_sign & b_sign;
        end else if (overflow) begin
            fpu_out_d = {big_sign, 15'h7C00};
            flag_v    = 1'b1;
        end
        cond_codes_d = {flag_z, flag_c, flag_n, flag_v};
    end

    // Output register; asynchronous reset discards any in-flight result
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            fpu_out_q    <= 16'h0000;
            cond_codes_q <= 4'b0000;
        end else begin
            fpu_out_q    <= fpu_out_d;
            cond_codes_q <= cond_codes_d;
        end
    end

    assign fpuOut    = fpu_out_q;
    assign condCodes = cond_codes_q;

endmodule

// File: tb/tb_fpu_add_sub_16.sv
// tb/tb_fpu_add_sub_16.sv - scoreboard bench for fpu_add_sub_16
module tb_fpu_add_sub_16;

    logic        clock;
    logic        reset_L;
    logic        sub;
    logic [15:0] fpuIn1;
    logic [15:0] fpuIn2;
    logic [15:0] fpuOut;
    logic [3:0]  condCodes;

    int tests_run;
    int tests_failed;

    // Expected {ZCNV, result} for each issued operation, oldest first
    logic [19:0] sb_q [$];

    fpu_add_sub_16 dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .sub       (sub),
        .fpuIn1    (fpuIn1),
        .fpuIn2    (fpuIn2),
        .fpuOut    (fpuOut),
        .condCodes (condCodes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one operation, record its expectation, and step to just after the capturing edge
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] eo, input logic [3:0] ec);
        fpuIn1 = a;
        fpuIn2 = b;
        sub    = s;
        sb_q.push_back({ec, eo});
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [19:0] exp_v;
        reset_L = 1'b0;
        sub     = 1'b0;
        fpuIn1  = 16'h4000;
        fpuIn2  = 16'h3C00;
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if ({condCodes, fpuOut} !== 20'h0_0000) begin
            tests_failed++;
            $display("FAIL reset_initial: got out=%h zcnv=%b, need out=0000 zcnv=0000", fpuOut, condCodes);
        end
        reset_L = 1'b1;
        issue(16'h4000, 16'h3C00, 1'b0, 16'h4200, 4'b0000);
        exp_v = sb_q.pop_front();
        tests_run++;
        if ({condCodes, fpuOut} !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_pre_op: got out=%h zcnv=%b, need out=%h zcnv=%b", fpuOut, condCodes, exp_v[15:0], exp_v[19:16]);
        end
        // Mid-cycle reset: must clear without waiting for a clock edge
        fpuIn1 = 16'h5EF0;
        fpuIn2 = 16'h621E;
        #2;
        reset_L = 1'b0;
        #1;
        tests_run++;
        if ({condCodes, fpuOut} !== 20'h0_0000) begin
            tests_failed++;
            $display("FAIL reset_async: got out=%h zcnv=%b, need out=0000 zcnv=0000", fpuOut, condCodes);
        end
        @(posedge clock);
        #1;
        tests_run++;
        if ({condCodes, fpuOut} !== 20'h0_0000) begin
            tests_failed++;
            $display("FAIL reset_held: got out=%h zcnv=%b, need out=0000 zcnv=0000", fpuOut, condCodes);
        end
        reset_L = 1'b1;
    endtask

    // Vector layout: {a[16], b[16], sub[1], out[16], zcnv[4]}
    task automatic test_add();
        logic [52:0] tbl [$];
        logic [19:0] exp_v;
        tbl = '{
            {16'h3C00, 16'h0000, 1'b0, 16'h3C00, 4'b0000},
            {16'h4000, 16'h3C00, 1'b0, 16'h4200, 4'b0000},
            {16'h4400, 16'h4000, 1'b0, 16'h4600, 4'b0000},
            {16'h4400, 16'h4C40, 1'b0, 16'h4D40, 4'b0000},
            {16'h5EF0, 16'h621E, 1'b0, 16'h64CB, 4'b0100},
            {16'h3C00, 16'h0001, 1'b0, 16'h3C00, 4'b0000}
        };
        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i][52:37], tbl[i][36:21], tbl[i][20], tbl[i][19:4], tbl[i][3:0]);
            exp_v = sb_q.pop_front();
            tests_run++;
            if ({condCodes, fpuOut} !== exp_v) begin
                tests_failed++;
                $display("FAIL add[%0d] %h+%h: got out=%h zcnv=%b, need out=%h zcnv=%b",
                         i, tbl[i][52:37], tbl[i][36:21], fpuOut, condCodes, exp_v[15:0], exp_v[19:16]);
            end
        end
    endtask

    task automatic test_sub_mixed();
        logic [52:0] tbl [$];
        logic [19:0] exp_v;
        tbl = '{
            {16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b1000},
            {16'h3C00, 16'h4000, 1'b1, 16'hBC00, 4'b0010},
            {16'h4900, 16'h4200, 1'b1, 16'h4700, 4'b0000},
            {16'h5E38, 16'h5280, 1'b1, 16'h5D68, 4'b0000},
            {16'hBC00, 16'h3C00, 1'b0, 16'h0000, 4'b1000},
            {16'hBC00, 16'h4500, 1'b0, 16'h4400, 4'b0000},
            {16'hEA45, 16'h6CE7, 1'b0, 16'h6712, 4'b0000},
            {16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b1010},
            {16'h0400, 16'h0001, 1'b1, 16'h03FF, 4'b0000}
        };
        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i][52:37], tbl[i][36:21], tbl[i][20], tbl[i][19:4], tbl[i][3:0]);
            exp_v = sb_q.pop_front();
            tests_run++;
            if ({condCodes, fpuOut} !== exp_v) begin
                tests_failed++;
                $display("FAIL sub_mixed[%0d] %h op%0d %h: got out=%h zcnv=%b, need out=%h zcnv=%b",
                         i, tbl[i][52:37], tbl[i][20], tbl[i][36:21], fpuOut, condCodes, exp_v[15:0], exp_v[19:16]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [52:0] tbl [$];
        logic [19:0] exp_v;
        tbl = '{
            {16'hDEF0, 16'h7062, 1'b0, 16'h702A, 4'b0000},
            {16'h3BFF, 16'h0C00, 1'b0, 16'h3C00, 4'b0000},
            {16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000}
        };
        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i][52:37], tbl[i][36:21], tbl[i][20], tbl[i][19:4], tbl[i][3:0]);
            exp_v = sb_q.pop_front();
            tests_run++;
            if ({condCodes, fpuOut} !== exp_v) begin
                tests_failed++;
                $display("FAIL round[%0d] %h+%h: got out=%h zcnv=%b, need out=%h zcnv=%b",
                         i, tbl[i][52:37], tbl[i][36:21], fpuOut, condCodes, exp_v[15:0], exp_v[19:16]);
            end
        end
    endtask

    task automatic test_specials();
        logic [52:0] tbl [$];
        logic [19:0] exp_v;
        tbl = '{
            {16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101},
            {16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b0000},
            {16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000},
            {16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'b0000},
            {16'hFC00, 16'h3C00, 1'b1, 16'hFC00, 4'b0010},
            {16'hFC00, 16'h7C00, 1'b1, 16'hFC00, 4'b0010},
            {16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 4'b0010}
        };
        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i][52:37], tbl[i][36:21], tbl[i][20], tbl[i][19:4], tbl[i][3:0]);
            exp_v = sb_q.pop_front();
            tests_run++;
            if ({condCodes, fpuOut} !== exp_v) begin
                tests_failed++;
                $display("FAIL special[%0d] %h op%0d %h: got out=%h zcnv=%b, need out=%h zcnv=%b",
                         i, tbl[i][52:37], tbl[i][20], tbl[i][36:21], fpuOut, condCodes, exp_v[15:0], exp_v[19:16]);
            end
        end
    endtask

    // Back-to-back random finite operands: x + 0 == x and x - x == +0, one op per cycle
    task automatic test_back_to_back();
        logic [15:0] x;
        logic [19:0] exp_v;
        for (int i = 0; i < 16; i++) begin
            x = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom)};
            issue(x, 16'h0000, 1'b0, x, {2'b00, x[15], 1'b0});
            exp_v = sb_q.pop_front();
            tests_run++;
            if ({condCodes, fpuOut} !== exp_v) begin
                tests_failed++;
                $display("FAIL b2b_plus_zero %h: got out=%h zcnv=%b, need out=%h zcnv=%b",
                         x, fpuOut, condCodes, exp_v[15:0], exp_v[19:16]);
            end
            issue(x, x, 1'b1, 16'h0000, 4'b1000);
            exp_v = sb_q.pop_front();
            tests_run++;
            if ({condCodes, fpuOut} !== exp_v) begin
                tests_failed++;
                $display("FAIL b2b_self_sub %h: got out=%h zcnv=%b, need out=%h zcnv=%b",
                         x, fpuOut, condCodes, exp_v[15:0], exp_v[19:16]);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_add();
        test_sub_mixed();
        test_rounding();
        test_specials();
        test_back_to_back();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending, need 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
